seq_mag_comparator: RTL and testbench
=====================================

Name: seq_mag_comparator

Overview:
- Parametrised, clocked successor of the team's 6-bit equality/inequality comparator.
- Compares two WIDTH-bit operands serially, MSB slice first, SLICE bits per cycle.
- Produces eq/lt/gt flags plus one selected relational result (EQ, NEQ, LT, LE, GT, GE), unsigned or two's-complement.
- Start/busy/done handshake; sits beside the datapath where area matters more than single-cycle latency.

Parameters:
- WIDTH, 6, operand width in bits; must be at least 2.
- SLICE, 2, bits examined per cycle; WIDTH % SLICE must be 0, else elaboration error.
- NSLICE, WIDTH/SLICE, derived local parameter; slices per operand.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- mode  input  3  000 EQ, 001 NEQ, 010 LT, 011 LE, 100 GT, 101 GE, 110/111 reserved.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high while comparing.
- done  output  1  one-cycle pulse; result, eq, lt, gt valid.
- result  output  1  selected relation of A vs B.
- eq  output  1  A == B.
- lt  output  1  A < B.
- gt  output  1  A > B.

Behaviour:
- One clock, synchronous active-high reset; all state registered on the rising edge of clk.
- Reset values: state IDLE, busy=0, done=0, result=0, eq=0, lt=0, gt=0, slice index=0.
- A reset mid-operation aborts the compare. No done pulse is produced.
- States:
  - IDLE: busy=0. start=1 latches a, b, mode, is_signed; next state RUN; slice index=0 (top slice).
  - RUN: busy=1; compares slice A[WIDTH-1-i*SLICE -: SLICE] vs the same slice of B, unsigned.
    - Slices differ: set lt/gt from that slice, eq=0, go to DONE.
    - Slices equal and i==NSLICE-1: eq=1, lt=0, gt=0, go to DONE.
    - Otherwise: i increments.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
    - start=1 in DONE is accepted (back-to-back) and goes straight to RUN.
- Signed handling: when is_signed=1, invert the MSB of both latched operands at latch time (offset-binary). The serial compare is then unsigned.
- Result mapping:
  - EQ=eq, NEQ=!eq, LT=lt, LE=lt|eq, GT=gt, GE=gt|eq.
  - Reserved modes give result=0; flags are still valid.
- eq/lt/gt/result update only on entry to DONE and hold until the next accepted start. On that start they clear to 0.
- start while busy=1 is ignored. Inputs a, b, mode and is_signed may change freely after the start cycle.
- Latency, with start sampled at edge E0:
  - Equal operands: done is high in the cycle after edge E(NSLICE).
  - First differing slice k: see Optional Feature.

Optional Feature:
- Macro: SEQ_MAG_COMPARATOR_EARLY_EXIT_EN.
- Defined: RUN leaves at the first differing slice k. done follows edge E(k+1).
- Undefined: the first difference is recorded, but RUN always runs all NSLICE slices. Latency is constant at NSLICE cycles, and flags/result are identical to the defined build.

Test Plan:
- Reset mid-RUN: start with a=6'b101010, b=6'b101011, then assert reset after 1 cycle -> busy=0, done never pulses, all outputs 0.
- Equality, defaults: a=6'b000001, b=6'b000001, mode=000 -> done at E3, eq=1, result=1; mode=001 on the same operands -> result=0.
- Unsigned magnitude: a=6'b111111, b=6'b000001, mode=100, is_signed=0 -> gt=1, result=1.
  - With EARLY_EXIT_EN: done at E1.
  - Without EARLY_EXIT_EN: done at E3.
- Signed: same operands, is_signed=1 (-1 vs +1), mode=010 -> lt=1, result=1; mode=101 -> result=0.
- Back-to-back and ignored start: start held high across three compares (6'b001010 vs 6'b000111 GT, then 6'b101010 vs 6'b010101 NEQ, then equal LE).
  - Three done pulses with results 1, 1, 1.
  - Starts asserted while busy=1 are ignored.
- Parameter sweep: WIDTH=16, SLICE=4, a=16'h8000, b=16'h7FFF, unsigned mode 100 -> gt=1. Signed -> lt=1, gt=0.

Source files
------------

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: serial MSB-first magnitude comparator, SLICE bits per cycle.
// Relational result is selected by mode (EQ/NEQ/LT/LE/GT/GE); is_signed selects
// a two's-complement compare by flipping both MSBs at latch time (offset binary).
// Optional macro SEQ_MAG_COMPARATOR_EARLY_EXIT_EN: leave RUN at the first
// differing slice. Without it, every compare takes exactly NSLICE cycles.
module seq_mag_comparator #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned SLICE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Reject illegal parameter combinations at elaboration
  if ((WIDTH < 2) || (SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("seq_mag_comparator: WIDTH must be >= 2 and a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       mode_q;

`ifndef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
  logic found;
  logic rec_lt;
  logic rec_gt;
`endif

  logic [SLICE-1:0] sa_c;
  logic [SLICE-1:0] sb_c;
  logic             sl_lt_c;
  logic             sl_gt_c;
  logic             last_c;
  logic             exit_c;
  logic             fin_lt_c;
  logic             fin_gt_c;
  logic             fin_eq_c;

  // Map the final flags onto the relation requested by mode
  function automatic logic sel_rel(input logic [2:0] m, input logic e, input logic l,
                                   input logic g);
    case (m)
      3'b000:  sel_rel = e;
      3'b001:  sel_rel = ~e;
      3'b010:  sel_rel = l;
      3'b011:  sel_rel = l | e;
      3'b100:  sel_rel = g;
      3'b101:  sel_rel = g | e;
      default: sel_rel = 1'b0;
    endcase
  endfunction

  // Current top slice of each shifting operand
  assign sa_c    = a_sh[WIDTH-1 -: SLICE];
  assign sb_c    = b_sh[WIDTH-1 -: SLICE];
  assign sl_lt_c = (sa_c < sb_c);
  assign sl_gt_c = (sa_c > sb_c);

  // Decide whether RUN ends this cycle and what the final flags would be
  always_comb begin
    last_c = (idx == IDXW'(NSLICE - 1));
`ifdef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
    fin_lt_c = sl_lt_c;
    fin_gt_c = sl_gt_c;
    exit_c   = last_c | sl_lt_c | sl_gt_c;
`else
    fin_lt_c = found ? rec_lt : sl_lt_c;
    fin_gt_c = found ? rec_gt : sl_gt_c;
    exit_c   = last_c;
`endif
    fin_eq_c = ~(fin_lt_c | fin_gt_c);
  end

  // Control FSM, operand shifters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      idx    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      mode_q <= 3'b000;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      gt     <= 1'b0;
`ifndef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
      found  <= 1'b0;
      rec_lt <= 1'b0;
      rec_gt <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (start) begin
            a_sh   <= is_signed ? {~a[WIDTH-1], a[WIDTH-2:0]} : a;
            b_sh   <= is_signed ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;
            mode_q <= mode;
            idx    <= '0;
            busy   <= 1'b1;
            result <= 1'b0;
            eq     <= 1'b0;
            lt     <= 1'b0;
            gt     <= 1'b0;
            state  <= ST_RUN;
`ifndef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
            found  <= 1'b0;
            rec_lt <= 1'b0;
            rec_gt <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (exit_c) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            eq     <= fin_eq_c;
            lt     <= fin_lt_c;
            gt     <= fin_gt_c;
            result <= sel_rel(mode_q, fin_eq_c, fin_lt_c, fin_gt_c);
            state  <= ST_DONE;
          end else begin
            idx  <= idx + IDXW'(1);
            a_sh <= a_sh << SLICE;
            b_sh <= b_sh << SLICE;
`ifndef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
            if (!found && (sl_lt_c || sl_gt_c)) begin
              found  <= 1'b1;
              rec_lt <= sl_lt_c;
              rec_gt <= sl_gt_c;
            end
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator: a 6-bit/2-bit instance and a
// 16-bit/4-bit instance share one clock; expected flags and latency are
// queued when a compare is launched and checked when done pulses.
module tb_seq_mag_comparator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 6-bit instance
  logic       start6, sgn6, busy6, done6, res6, eq6, lt6, gt6;
  logic [2:0] mode6;
  logic [5:0] a6, b6;

  // 16-bit instance
  logic        start16, sgn16, busy16, done16, res16, eq16, lt16, gt16;
  logic [2:0]  mode16;
  logic [15:0] a16, b16;

  seq_mag_comparator #(.WIDTH(6), .SLICE(2)) dut6 (
    .clk(clk), .reset(reset), .start(start6), .mode(mode6), .is_signed(sgn6),
    .a(a6), .b(b6), .busy(busy6), .done(done6), .result(res6),
    .eq(eq6), .lt(lt6), .gt(gt6)
  );

  seq_mag_comparator #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .mode(mode16), .is_signed(sgn16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .result(res16),
    .eq(eq16), .lt(lt16), .gt(gt16)
  );

  typedef struct {
    logic eq;
    logic lt;
    logic gt;
    logic res;
    int   lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model from the integer values of the operands
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int w,
                                 input int s, input logic [2:0] m, input logic sgn);
    exp_t   e;
    longint av, bv;
    int     k;
    logic [15:0] sa, sbv;
    av = longint'(a);
    bv = longint'(b);
    if (sgn && a[w-1]) av = av - (longint'(1) << w);
    if (sgn && b[w-1]) bv = bv - (longint'(1) << w);
    e.eq = (av == bv);
    e.lt = (av < bv);
    e.gt = (av > bv);
    case (m)
      3'b000:  e.res = e.eq;
      3'b001:  e.res = !e.eq;
      3'b010:  e.res = e.lt;
      3'b011:  e.res = e.lt || e.eq;
      3'b100:  e.res = e.gt;
      3'b101:  e.res = e.gt || e.eq;
      default: e.res = 1'b0;
    endcase
    k = w / s;
    for (int i = w / s - 1; i >= 0; i--) begin
      sa  = (a >> (w - (i + 1) * s)) & ((16'd1 << s) - 16'd1);
      sbv = (b >> (w - (i + 1) * s)) & ((16'd1 << s) - 16'd1);
      if (sa != sbv) k = i + 1;
    end
`ifdef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
    e.lat = k;
`else
    e.lat = w / s;
`endif
    return e;
  endfunction

  function automatic logic [5:0] outs(input bit wide);
    if (wide) return {busy16, done16, res16, eq16, lt16, gt16};
    return {busy6, done6, res6, eq6, lt6, gt6};
  endfunction

  // Count edges after the accept edge until done is seen (bounded)
  task automatic wait_done(input bit wide, output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if ((wide ? done16 : done6) === 1'b1) begin
        lat = c;
        return;
      end
    end
  endtask

  // Pop the oldest expectation and compare it against the current outputs
  task automatic check_out(input string tag, input bit wide, input int lat);
    exp_t e;
    logic [5:0] o;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    o = outs(wide);
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk({tag, "_busy"}, 32'(o[5]), 32'd0);
    chk({tag, "_eq"}, 32'(o[2]), 32'(e.eq));
    chk({tag, "_lt"}, 32'(o[1]), 32'(e.lt));
    chk({tag, "_gt"}, 32'(o[0]), 32'(e.gt));
    chk({tag, "_result"}, 32'(o[3]), 32'(e.res));
  endtask

  task automatic drive(input bit wide, input logic st, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] m, input logic sgn);
    if (wide) begin
      start16 = st; a16 = a; b16 = b; mode16 = m; sgn16 = sgn;
    end else begin
      start6 = st; a6 = a[5:0]; b6 = b[5:0]; mode6 = m; sgn6 = sgn;
    end
  endtask

  // Single compare: launch, check busy, wait for done, check result and hold
  task automatic run_one(input string tag, input bit wide, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] m, input logic sgn);
    int lat;
    logic [5:0] o_done, o_hold;
    sb.push_back(model(a, b, wide ? 16 : 6, wide ? 4 : 2, m, sgn));
    @(negedge clk);
    drive(wide, 1'b1, a, b, m, sgn);
    @(posedge clk);
    #1;
    drive(wide, 1'b0, ~a, ~b, ~m, ~sgn);
    chk({tag, "_busy_run"}, 32'(outs(wide) >> 5), 32'd1);
    wait_done(wide, lat);
    o_done = outs(wide);
    check_out(tag, wide, lat);
    @(posedge clk);
    #1;
    o_hold = outs(wide);
    chk({tag, "_done_pulse"}, 32'(o_hold[4]), 32'd0);
    chk({tag, "_hold"}, 32'(o_hold[3:0]), 32'(o_done[3:0]));
  endtask

  initial begin
    int lat;
    int extra;
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs6", 32'(outs(1'b0)), 32'd0);
    chk("reset_outputs16", 32'(outs(1'b1)), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset one cycle into RUN aborts the compare
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h002A, 16'h002B, 3'b000, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0);
    chk("abort_busy_before", 32'(busy6), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_outputs", 32'(outs(1'b0)), 32'd0);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done6 === 1'b1) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'd0);

    // Equality and NEQ on equal operands
    run_one("eq_mode_eq", 1'b0, 16'h0001, 16'h0001, 3'b000, 1'b0);
    run_one("eq_mode_neq", 1'b0, 16'h0001, 16'h0001, 3'b001, 1'b0);
    // Unsigned magnitude, first slice differs
    run_one("uns_gt", 1'b0, 16'h003F, 16'h0001, 3'b100, 1'b0);
    // Signed: -1 vs +1
    run_one("sgn_lt", 1'b0, 16'h003F, 16'h0001, 3'b010, 1'b1);
    run_one("sgn_ge", 1'b0, 16'h003F, 16'h0001, 3'b101, 1'b1);
    // Difference only in the last slice, and a reserved mode
    run_one("last_slice_le", 1'b0, 16'h0014, 16'h0016, 3'b011, 1'b0);
    run_one("reserved_mode", 1'b0, 16'h0020, 16'h0010, 3'b110, 1'b0);

    // Back-to-back with start held high throughout
    sb.push_back(model(16'h000A, 16'h0007, 6, 2, 3'b100, 1'b0));
    sb.push_back(model(16'h002A, 16'h0015, 6, 2, 3'b001, 1'b0));
    sb.push_back(model(16'h0011, 16'h0011, 6, 2, 3'b011, 1'b0));
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h000A, 16'h0007, 3'b100, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 16'h002A, 16'h0015, 3'b001, 1'b0);
    wait_done(1'b0, lat);
    check_out("b2b_1", 1'b0, lat);
    @(posedge clk);
    #1;
    chk("b2b_accept2", 32'(busy6), 32'd1);
    drive(1'b0, 1'b1, 16'h0011, 16'h0011, 3'b011, 1'b0);
    wait_done(1'b0, lat);
    check_out("b2b_2", 1'b0, lat);
    @(posedge clk);
    #1;
    chk("b2b_accept3", 32'(busy6), 32'd1);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0);
    wait_done(1'b0, lat);
    check_out("b2b_3", 1'b0, lat);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (done6 === 1'b1) extra++;
    end
    chk("b2b_no_extra_done", 32'(extra), 32'd0);

    // Wider instance: 0x8000 vs 0x7FFF unsigned and signed
    run_one("w16_uns_gt", 1'b1, 16'h8000, 16'h7FFF, 3'b100, 1'b0);
    run_one("w16_sgn_gt", 1'b1, 16'h8000, 16'h7FFF, 3'b100, 1'b1);
    run_one("w16_eq", 1'b1, 16'hA5C3, 16'hA5C3, 3'b101, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
